// File: rtl/ssd_scan_driver.sv
// N-digit seven-segment scan driver with an internal double-dabble binary-to-BCD converter.
// Optional build macro SSD_LZ_BLANK_EN blanks leading zeros (digit 0 is always shown).
module ssd_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value_i,
    input  logic              load_i,
    output logic              busy_o,
    output logic [DIGITS-1:0] Anode,
    output logic [6:0]        LED_out
);

    // Work BCD must hold any DATA_W value; never fewer nibbles than displayed digits
    localparam int BCD_RAW = (DATA_W * 302) / 1000 + 1;
    localparam int BCD_N   = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
    localparam int WB      = BCD_N * 4;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   shreg;
    logic [WB-1:0]       work, work_adj;
    logic [CNT_W-1:0]    cnt;
    logic [DIGITS*4-1:0] disp;
    logic                ovf, work_ovf;
    logic [REF_W-1:0]    ref_cnt;
    logic [IDX_W-1:0]    idx;
    logic [6:0]          seg_nx;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'b0000001;
            4'd1:    seg_enc = 7'b1001111;
            4'd2:    seg_enc = 7'b0010010;
            4'd3:    seg_enc = 7'b0000110;
            4'd4:    seg_enc = 7'b1001100;
            4'd5:    seg_enc = 7'b0100100;
            4'd6:    seg_enc = 7'b0100000;
            4'd7:    seg_enc = 7'b0001111;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0000100;
            default: seg_enc = 7'b1111111;
        endcase
    endfunction

    assign busy_o = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load_i) state_nx = SHIFT;
            SHIFT:   if (cnt == CNT_W'(DATA_W - 1)) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        work_adj = work;
        for (int i = 0; i < BCD_N; i++)
            if (work[i*4 +: 4] >= 4'd5) work_adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
    end

    // Any non-zero nibble above the displayed digits means value >= 10**DIGITS
    always_comb begin
        work_ovf = 1'b0;
        for (int i = DIGITS; i < BCD_N; i++)
            if (work[i*4 +: 4] != 4'd0) work_ovf = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            work  <= '0;
            cnt   <= '0;
            disp  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (load_i) begin
                    shreg <= value_i;
                    work  <= '0;
                    cnt   <= '0;
                end
                SHIFT: begin
                    work  <= {work_adj[WB-2:0], shreg[DATA_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                end
                COMMIT: begin
                    disp <= work[DIGITS*4-1:0];
                    ovf  <= work_ovf;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++)
            if (j > int'(idx) && disp[j*4 +: 4] != 4'd0) upper_zero = 1'b0;
        if (ovf)
            seg_nx = 7'b1111110;
`ifdef SSD_LZ_BLANK_EN
        else if (upper_zero && idx != '0 && disp[idx*4 +: 4] == 4'd0)
            seg_nx = 7'b1111111;
`endif
        else
            seg_nx = seg_enc(disp[idx*4 +: 4]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            Anode   <= '1;
            LED_out <= 7'h7F;
        end else begin
            if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            Anode   <= ~(DIGITS'(1) << idx);
            LED_out <= seg_nx;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomized self-checking bench for ssd_scan_driver against a decimal-arithmetic display model.
module tb_ssd_scan_driver;
    localparam int DIGITS = 4, DATA_W = 14, REFRESH_DIV = 4;

    logic              clk, rst, load_i, busy_o;
    logic [DATA_W-1:0] value_i;
    logic [DIGITS-1:0] Anode;
    logic [6:0]        LED_out;
    int n_chk = 0, n_err = 0;

    ssd_scan_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i),
        .busy_o(busy_o), .Anode(Anode), .LED_out(LED_out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] enc(input int d);
        logic [6:0] t [10];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return t[d];
    endfunction

    // Segment pattern a decimal display of v shows at position pos
    function automatic logic [6:0] exp_seg(input int v, input int pos);
        if (v >= 10 ** DIGITS) return 7'b1111110;
`ifdef SSD_LZ_BLANK_EN
        if (pos > 0 && v < 10 ** pos) return 7'b1111111;
`endif
        return enc((v / (10 ** pos)) % 10);
    endfunction

    task automatic do_load(input int v, output int busy_cycles);
        value_i = DATA_W'(v);
        load_i  = 1;
        tick;
        load_i  = 0;
        busy_cycles = 0;
        while (busy_o && busy_cycles < 100) begin
            busy_cycles++;
            tick;
        end
    endtask

    // Watch ~6 digit periods: one-hot anode, right segments, dwell and order
    task automatic scan_check(input int v);
        int prev = -1, run = 0, nchg = 0, cur;
        tick;
        for (int c = 0; c < 6 * DIGITS; c++) begin
            cur = -1;
            for (int i = 0; i < DIGITS; i++)
                if (Anode == ~(DIGITS'(1) << i)) cur = i;
            chk("anode_onehot", 32'(cur >= 0), 1);
            if (cur >= 0) begin
                chk($sformatf("seg v=%0d d=%0d", v, cur), 32'(LED_out), 32'(exp_seg(v, cur)));
                if (cur != prev) begin
                    if (prev >= 0) begin
                        chk("scan_order", 32'(cur), 32'((prev + 1) % DIGITS));
                        if (nchg > 0) chk("dwell", 32'(run), REFRESH_DIV);
                        nchg++;
                    end
                    prev = cur;
                    run  = 1;
                end else run++;
            end
            tick;
        end
    endtask

    initial begin
        int bc, falls, pb, v;
        rst = 0; load_i = 0; value_i = '0;
        repeat (3) tick;
        chk("rst_anode", 32'(Anode), 32'hF);
        chk("rst_led", 32'(LED_out), 32'h7F);
        chk("rst_busy", 32'(busy_o), 0);
        @(negedge clk) rst = 1;
        tick;
        chk("rel_anode", 32'(Anode), 32'hE);
        chk("rel_led", 32'(LED_out), 32'b0000001);
        scan_check(0);

        do_load(1234, bc);
        chk("busy_len_1234", 32'(bc), DATA_W + 1);
        scan_check(1234);

        do_load(10000, bc);
        chk("busy_len_10000", 32'(bc), DATA_W + 1);
        scan_check(10000);
        do_load(9999, bc);
        scan_check(9999);

        // Second load during busy must be dropped
        value_i = 42; load_i = 1; tick; load_i = 0;
        tick; tick;
        value_i = 77; load_i = 1; tick; load_i = 0;
        falls = 0; pb = 1;
        for (int c = 0; c < 60; c++) begin
            if (pb && !busy_o) falls++;
            pb = busy_o;
            tick;
        end
        chk("busy_falls", 32'(falls), 1);
        scan_check(42);

        // Reset mid-conversion
        value_i = 5678; load_i = 1; tick; load_i = 0;
        repeat (5) tick;
        chk("shift6_busy", 32'(busy_o), 1);
        #2 rst = 0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_anode", 32'(Anode), 32'hF);
        chk("mid_rst_led", 32'(LED_out), 32'h7F);
        @(negedge clk) rst = 1;
        scan_check(0);

        do_load(7, bc);
        scan_check(7);

        for (int it = 0; it < 10; it++) begin
            v = (it % 3 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383));
            do_load(v, bc);
            chk("busy_len_rand", 32'(bc), DATA_W + 1);
            scan_check(v);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
